// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the loader FSM state encoding and the default memory capacity
// in 32-bit words. Both are used by the loader and by its bench.
package program_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_e;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream and memory-write bundle of the program loader.
//   byteIn/byteValid/byteReady : incoming byte handshake
//   memWrite/memAddress/memWriteData : shared memory write port
//   cpuReset/loadDone/loadError : load status towards the CPU
// master = byte source / memory / CPU side, slave = the loader.
interface program_loader_if;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;

    modport master (
        output byteIn, byteValid,
        input  byteReady, memWrite, memAddress, memWriteData,
               cpuReset, loadDone, loadError
    );

    modport slave (
        input  byteIn, byteValid,
        output byteReady, memWrite, memAddress, memWriteData,
               cpuReset, loadDone, loadError
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Big-endian word assembler: shifts accepted bytes into a 32-bit
// register (first byte ends up in [31:24]) and counts them mod 4.
//   clock_i, reset_i : clock, synchronous active-high reset
//   clear_i          : drop any partial word
//   shift_i          : a byte is accepted this cycle
//   byte_i           : the byte
//   word_o           : assembled word
//   last_o           : this shift completes the word (4th byte)
module byte_assembler (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);
    logic [31:0] word_q;
    logic [1:0]  count_q;

    assign word_o = word_q;
    assign last_o = shift_i && (count_q == 2'd3);

    always_ff @(posedge clock_i) begin
        if (reset_i || clear_i) begin
            word_q  <= '0;
            count_q <= '0;
        end else if (shift_i) begin
            word_q  <= {word_q[23:0], byte_i};
            count_q <= count_q + 2'd1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Program loader: parses a byte stream of a 16-bit word count N
// (high byte first) followed by N big-endian words, and writes the
// words to consecutive addresses from BASE_ADDRESS. Holds the CPU in
// reset until the whole program is written.
//   clock, reset : clock, synchronous active-high reset
//   bus          : byte handshake, memory write port and status flags
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned MEM_WORDS    = MEM_WORDS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus
);
    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic        byte_ready;
    logic        accept;
    logic        asm_clear;
    logic        asm_last;
    logic [31:0] asm_word;

    assign byte_ready = !reset &&
        (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA);
    assign accept = bus.byteValid && byte_ready;

    byte_assembler u_asm (
        .clock_i (clock),
        .reset_i (reset),
        .clear_i (asm_clear),
        .shift_i (accept && (state_q == DATA)),
        .byte_i  (bus.byteIn),
        .word_o  (asm_word),
        .last_o  (asm_last)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        asm_clear  = 1'b0;
        case (state_q)
            HDR_HI: if (accept) begin
                n_d     = {bus.byteIn, n_q[7:0]};
                state_d = HDR_LO;
            end
            HDR_LO: if (accept) begin
                n_d = {n_q[15:8], bus.byteIn};
                if (n_d == 16'd0)
                    state_d = DONE;
                else if (32'(n_d) > MEM_WORDS)
                    state_d = ERROR;
                else begin
                    state_d    = DATA;
                    word_idx_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            DATA: if (asm_last) state_d = WRITE;
            WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_d == n_q) ? DONE : DATA;
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = HDR_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= HDR_HI;
            n_q        <= '0;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
        end
    end

    // Address wraps modulo 2^32 by construction of the 32-bit add.
    assign bus.byteReady    = byte_ready;
    assign bus.memWrite     = !reset && (state_q == WRITE);
    assign bus.memAddress   = BASE_ADDRESS + {14'd0, word_idx_q, 2'b00};
    assign bus.memWriteData = asm_word;
    assign bus.cpuReset     = reset || (state_q != DONE);
    assign bus.loadDone     = !reset && (state_q == DONE);
    assign bus.loadError    = !reset && (state_q == ERROR);
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    import program_loader_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    program_loader_if if0 ();
    program_loader_if if1 ();

    program_loader #(.BASE_ADDRESS(32'h0000_0000), .MEM_WORDS(256)) dut0 (
        .clock (clock), .reset (reset), .bus (if0.slave));
    program_loader #(.BASE_ADDRESS(32'h0000_0400), .MEM_WORDS(256)) dut1 (
        .clock (clock), .reset (reset), .bus (if1.slave));

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  b;
        logic        rdy;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        cpu;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic v, input logic [7:0] b,
                       input logic rdy, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic cpu, input logic done,
                       input logic err);
        vec_t r;
        r.rst = rst; r.v = v; r.b = b; r.rdy = rdy; r.wr = wr; r.addr = addr;
        r.data = data; r.cpu = cpu; r.done = done; r.err = err;
        vt.push_back(r);
    endtask

    // Plain byte-accept step in HDR/DATA: ready, no write, CPU held.
    task automatic acc(input logic [7:0] b);
        add(0, 1, b, 1, 0, 0, 0, 1, 0, 0);
    endtask

    int          wcnt;
    logic [31:0] waddr, wdata;

    task automatic sample1();
        if (if1.memWrite) begin
            wcnt++;
            waddr = if1.memAddress;
            wdata = if1.memWriteData;
        end
    endtask

    initial begin
        logic [7:0] s1 [6];
        bit         got;

        if0.byteValid = 0; if0.byteIn = 0;
        if1.byteValid = 0; if1.byteIn = 0;

        // Two-word load, byteValid held high (01 presented during WRITE).
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        acc(8'h00); acc(8'h02);
        acc(8'hDE); acc(8'hAD); acc(8'hBE); acc(8'hEF);
        add(0, 1, 8'h01, 0, 1, 32'h0, 32'hDEADBEEF, 1, 0, 0);
        acc(8'h01); acc(8'h23); acc(8'h45); acc(8'h67);
        add(0, 0, 8'h00, 0, 1, 32'h4, 32'h01234567, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h55, 0, 0, 0, 0, 0, 1, 0);
        // Empty program.
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        acc(8'h00); acc(8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        // N=257 exceeds capacity.
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        acc(8'h01); acc(8'h01);
        add(0, 1, 8'hFF, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 8'hFF, 0, 0, 0, 0, 1, 0, 1);
        // Reset after two data bytes, then a clean one-word load.
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        acc(8'h00); acc(8'h01); acc(8'h11); acc(8'h22);
        add(1, 1, 8'h33, 0, 0, 0, 0, 1, 0, 0);
        acc(8'h00); acc(8'h01);
        acc(8'hAA); acc(8'hBB); acc(8'hCC); acc(8'hDD);
        add(0, 0, 8'h00, 0, 1, 32'h0, 32'hAABBCCDD, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        // N == MEM_WORDS is accepted.
        add(1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        acc(8'h01); acc(8'h00);
        add(0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clock);
            reset = vt[i].rst;
            if0.byteValid = vt[i].v;
            if0.byteIn = vt[i].b;
            #1;
            chk($sformatf("v%0d_rdy", i),  {31'd0, if0.byteReady}, {31'd0, vt[i].rdy});
            chk($sformatf("v%0d_wr", i),   {31'd0, if0.memWrite},  {31'd0, vt[i].wr});
            chk($sformatf("v%0d_cpu", i),  {31'd0, if0.cpuReset},  {31'd0, vt[i].cpu});
            chk($sformatf("v%0d_done", i), {31'd0, if0.loadDone},  {31'd0, vt[i].done});
            chk($sformatf("v%0d_err", i),  {31'd0, if0.loadError}, {31'd0, vt[i].err});
            if (vt[i].wr) begin
                chk($sformatf("v%0d_addr", i), if0.memAddress, vt[i].addr);
                chk($sformatf("v%0d_data", i), if0.memWriteData, vt[i].data);
            end
        end

        // One-word load with random byteValid gaps on the 0x400-based loader.
        @(negedge clock);
        reset = 1; if0.byteValid = 0; if1.byteValid = 0;
        @(negedge clock);
        reset = 0;
        wcnt = 0; waddr = 0; wdata = 0;
        s1[0] = 8'h00; s1[1] = 8'h01; s1[2] = 8'h12;
        s1[3] = 8'h34; s1[4] = 8'h56; s1[5] = 8'h78;
        for (int k = 0; k < 6; k++) begin
            int gap;
            gap = $urandom_range(0, 5);
            if1.byteValid = 0;
            for (int g = 0; g < gap; g++) begin
                #1 sample1();
                @(negedge clock);
            end
            if1.byteValid = 1;
            if1.byteIn = s1[k];
            got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                #1 sample1();
                if (if1.byteReady) got = 1;
                @(negedge clock);
            end
            if (!got) chk($sformatf("accept_timeout_%0d", k), 32'd0, 32'd1);
        end
        if1.byteValid = 0;
        for (int c = 0; c < 8; c++) begin
            #1 sample1();
            @(negedge clock);
        end
        #1;
        chk("gap_write_count", wcnt, 32'd1);
        chk("gap_write_addr", waddr, 32'h0000_0400);
        chk("gap_write_data", wdata, 32'h12345678);
        chk("gap_done", {31'd0, if1.loadDone}, 32'd1);
        chk("gap_cpu", {31'd0, if1.cpuReset}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h0000_0000, is the byte address at which the first loaded word is written.
REQ-002 Parameter MEM_WORDS, default 256, is the maximum number of 32-bit words the shared memory can accept.
REQ-003 clock  input  1  single clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 byteIn  input  8  incoming program byte.
REQ-006 byteValid  input  1  byteIn is valid this cycle.
REQ-007 byteReady  output  1  loader accepts a byte this cycle.
REQ-008 memWrite  output  1  write strobe to the shared instruction/data memory.
REQ-009 memAddress  output  32  word-aligned byte address for the write.
REQ-010 memWriteData  output  32  word to write.
REQ-011 cpuReset  output  1  held-in-reset request to the 5-stage CPU.
REQ-012 loadDone  output  1  program fully written.
REQ-013 loadError  output  1  header word count exceeds MEM_WORDS.

Function
REQ-014 A byte SHALL be accepted on a rising edge where byteValid and byteReady are both 1; bytes presented at any other time are ignored.
REQ-015 The stream format SHALL be: a 16-bit word count N (high byte first), then N words of 4 bytes each (big-endian, first byte -> [31:24]).
REQ-016 The FSM SHALL have exactly these states: HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
REQ-017 HDR_HI: on accept, latch N[15:8] and go to HDR_LO.
REQ-018 HDR_LO: on accept, latch N[7:0], then go to DONE if N==0, ERROR if N>MEM_WORDS, else DATA with wordIndex=0 and byteCount=0.
REQ-019 DATA: each accept shifts the byte into the assembly register and increments a 2-bit byteCount; the 4th accept goes to WRITE.
REQ-020 WRITE: lasts exactly one cycle, with memWrite=1, memAddress=BASE_ADDRESS+4*wordIndex and memWriteData=the assembled word.
REQ-021 On leaving WRITE, wordIndex SHALL increment; the next state is DONE if the new wordIndex==N, else DATA.
REQ-022 byteReady SHALL be 1 only in HDR_HI, HDR_LO and DATA with reset low; it is 0 in WRITE, DONE and ERROR.
REQ-023 Latency: if the 4th byte of a word is accepted at edge k, memWrite SHALL be high for exactly the cycle following edge k. Peak throughput is 1 word per 5 cycles.
REQ-024 memWrite SHALL be 0 in every state other than WRITE; memAddress and memWriteData are don't-care when memWrite=0.
REQ-025 cpuReset SHALL equal reset OR (state != DONE); the CPU runs only after a successful load.
REQ-026 loadDone SHALL be 1 exactly in DONE; loadError SHALL be 1 exactly in ERROR.
REQ-027 DONE and ERROR SHALL be terminal until reset; a byteValid level held high there has no effect.
REQ-028 wordIndex SHALL be 16 bits wide; address arithmetic is 32-bit and wraps modulo 2^32 with no overflow flag.
REQ-029 A valid byte that is present during WRITE SHALL be held off (byteReady=0) and accepted in the following DATA cycle; no byte may be lost.

Reset
REQ-030 On a reset edge: state=HDR_HI, N=0, wordIndex=0, byteCount=0, assembly register=0.
REQ-031 While reset=1: byteReady=0, memWrite=0, cpuReset=1, loadDone=0, loadError=0.
REQ-032 Reset mid-load (any state) SHALL discard the partial word and header, with no memWrite in the reset cycle or the cycle after it.

Structure
REQ-033 State encodings and the MEM_WORDS default SHALL live in the shared cpu definitions package/header.
REQ-034 Byte assembly (4-byte shift register plus byteCount) SHALL be one sub-module, byte_assembler; the FSM, counters and address generation stay in program_loader.

Verification
REQ-035 Stream 00 02 | DE AD BE EF | 01 23 45 67 with byteValid held at 1 -> writes {0x0:DEADBEEF}, {0x4:01234567}; loadDone=1 and cpuReset=0 from the cycle after the second write.
REQ-036 Stream 00 00 -> DONE after the 2nd accept; no memWrite at any point; cpuReset falls on the next cycle.
REQ-037 Header 01 01 (N=257) with MEM_WORDS=256 -> loadError=1, byteReady=0, cpuReset stays 1, no memWrite, and further bytes are ignored.
REQ-038 Header 00 01 with bytes spaced by random byteValid gaps of 0-5 cycles and BASE_ADDRESS=0x400 -> a single write of the correct word at 0x400; memWrite is high for exactly 1 cycle.
REQ-039 Reset asserted after the 2nd data byte of word 1, then the full 00 01 AA BB CC DD stream sent -> a single write {BASE:AABBCCDD}; no stale bytes appear in the word.
REQ-040 byteValid held high during the WRITE cycle -> the byte is not consumed during WRITE and the next word is assembled correctly, with no byte dropped or duplicated.
